// File: rtl/fofb_frame_gather.sv
// Gathers BPM records from one Aurora cell-link stream into a double-banked record store.
// FAstrobe swaps banks so readout always sees one complete frame; duplicates within a frame are flagged.
module fofb_frame_gather #(
  parameter int          FOFB_INDEX_WIDTH = 9,
  parameter int          CELL_INDEX_WIDTH = 5,
  parameter int          DATA_WORDS       = 3,
  parameter logic [15:0] MAGIC            = 16'hA5BE
) (
  input  logic                            auroraClk,
  input  logic                            auroraReset,
  input  logic                            FAstrobe,
  input  logic                            allBPMpresent,
  input  logic                            TVALID,
  input  logic                            TLAST,
  input  logic [31:0]                     TDATA,
  output logic                            statusStrobe,
  output logic [2:0]                      statusCode,
  output logic                            statusFOFBenabled,
  output logic [CELL_INDEX_WIDTH-1:0]     statusCellIndex,
  output logic [(1<<FOFB_INDEX_WIDTH)-1:0] bpmBitmap,
  output logic [CELL_INDEX_WIDTH:0]       cellCounter,
  output logic                            frontBank,
  input  logic [FOFB_INDEX_WIDTH-1:0]     readoutAddress,
  output logic [32*DATA_WORDS-1:0]        readoutData
);

  localparam int NREC = 1 << FOFB_INDEX_WIDTH;
  localparam int RW   = 32 * DATA_WORDS;
  localparam int WCW  = $clog2(DATA_WORDS);
  localparam logic [WCW-1:0]            LAST_WORD = WCW'(DATA_WORDS - 1);
  localparam logic [WCW-1:0]            WORD_ONE  = WCW'(1);
  localparam logic [CELL_INDEX_WIDTH:0] CNT_ONE   = (CELL_INDEX_WIDTH+1)'(1);

  localparam logic [2:0] ST_SUCCESS    = 3'd0;
  localparam logic [2:0] ST_BAD_HEADER = 3'd1;
  localparam logic [2:0] ST_BAD_SIZE   = 3'd2;
  localparam logic [2:0] ST_BAD_PACKET = 3'd3;
  localparam logic [2:0] ST_DUPLICATE  = 3'd4;

  typedef enum logic [1:0] {S_HEADER, S_DATA, S_LAST} state_t;

  state_t                      state_q, state_d;
  logic [WCW-1:0]              word_q, word_d;
  logic [RW-1:0]               rec_q, rec_d;
  logic [FOFB_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [2:0]                  code_q, code_d;
  logic                        enable_q, enable_d;
  logic [CELL_INDEX_WIDTH-1:0] cell_q, cell_d;
  logic [NREC-1:0]             bitmap_q, bitmap_d;
  logic [CELL_INDEX_WIDTH:0]   count_q, count_d;
  logic                        front_q, front_d;
  logic                        strobe_q, strobe_d;

  logic                        wr_en;
  logic [RW-1:0]               wr_data;
  logic [RW-1:0]               rd_data_q;
  logic [RW-1:0]               mem [2*NREC];
  logic                        unused_tdata;

  assign unused_tdata = ^TDATA;
  assign wr_data      = {TDATA, rec_q[RW-1:32]};

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    rec_d    = rec_q;
    idx_d    = idx_q;
    code_d   = code_q;
    enable_d = enable_q;
    cell_d   = cell_q;
    bitmap_d = bitmap_q;
    count_d  = count_q;
    front_d  = front_q;
    strobe_d = 1'b0;
    wr_en    = 1'b0;

    // The frame marker wins over any beat on the same cycle; that beat is lost.
    if (FAstrobe) begin
      front_d  = ~front_q;
      bitmap_d = '0;
      count_d  = '0;
      code_d   = ST_SUCCESS;
      state_d  = S_HEADER;
    end else if (TVALID) begin
      case (state_q)
        S_HEADER: begin
          if (TLAST) begin
            code_d   = ST_BAD_SIZE;
            strobe_d = 1'b1;
          end else if (TDATA[31:16] == MAGIC) begin
            idx_d    = TDATA[FOFB_INDEX_WIDTH-1:0];
            cell_d   = TDATA[10 +: CELL_INDEX_WIDTH];
            enable_d = TDATA[15];
            code_d   = ST_SUCCESS;
            word_d   = '0;
            state_d  = S_DATA;
          end else begin
            code_d   = ST_BAD_HEADER;
            strobe_d = 1'b1;
            state_d  = S_LAST;
          end
        end
        S_DATA: begin
          rec_d = wr_data;
          if (TLAST) begin
            code_d   = ST_BAD_SIZE;
            strobe_d = 1'b1;
            state_d  = S_HEADER;
          end else if (word_q == LAST_WORD) begin
            if (TDATA[30]) code_d = ST_BAD_PACKET;
            // bit31 clear means the BPM reported a record for this frame
            if (!TDATA[31]) begin
              if (bitmap_q[idx_q] && !TDATA[30]) code_d = ST_DUPLICATE;
              else if (!allBPMpresent)           wr_en  = 1'b1;
            end
            state_d = S_LAST;
          end else begin
            word_d = word_q + WORD_ONE;
          end
        end
        S_LAST: begin
          if (TLAST) begin
            strobe_d = 1'b1;
            if (code_q == ST_SUCCESS) begin
              if (count_q != '1)  count_d = count_q + CNT_ONE;
              if (!allBPMpresent) bitmap_d[idx_q] = 1'b1;
            end
            state_d = S_HEADER;
          end
        end
        default: state_d = S_HEADER;
      endcase
    end
  end

  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset) begin
      state_q  <= S_HEADER;
      word_q   <= '0;
      rec_q    <= '0;
      idx_q    <= '0;
      code_q   <= ST_SUCCESS;
      enable_q <= 1'b0;
      cell_q   <= '0;
      bitmap_q <= '0;
      count_q  <= '0;
      front_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      rec_q    <= rec_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      enable_q <= enable_d;
      cell_q   <= cell_d;
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      front_q  <= front_d;
      strobe_q <= strobe_d;
    end
  end

  // Record store is not reset so contents survive a link reset; bank bit is the MSB of the address.
  always_ff @(posedge auroraClk) begin
    if (wr_en) mem[{~front_q, idx_q}] <= wr_data;
    rd_data_q <= mem[{front_q, readoutAddress}];
  end

  assign statusStrobe      = strobe_q;
  assign statusCode        = code_q;
  assign statusFOFBenabled = enable_q;
  assign statusCellIndex   = cell_q;
  assign bpmBitmap         = bitmap_q;
  assign cellCounter       = count_q;
  assign frontBank         = front_q;
  assign readoutData       = rd_data_q;

endmodule

// File: tb/tb_fofb_frame_gather.sv
// Randomized bench for fofb_frame_gather against a packet-level reference model.
module tb_fofb_frame_gather;

  localparam int          FW    = 9;
  localparam int          CW    = 5;
  localparam int          DW    = 3;
  localparam logic [15:0] MAGIC = 16'hA5BE;
  localparam int          NREC  = 1 << FW;
  localparam int          RW    = 32 * DW;
  localparam int          CMAX  = (1 << (CW + 1)) - 1;

  logic            auroraClk = 1'b0;
  logic            auroraReset;
  logic            FAstrobe, allBPMpresent, TVALID, TLAST;
  logic [31:0]     TDATA;
  logic            statusStrobe;
  logic [2:0]      statusCode;
  logic            statusFOFBenabled;
  logic [CW-1:0]   statusCellIndex;
  logic [NREC-1:0] bpmBitmap;
  logic [CW:0]     cellCounter;
  logic            frontBank;
  logic [FW-1:0]   readoutAddress;
  logic [RW-1:0]   readoutData;

  fofb_frame_gather #(.FOFB_INDEX_WIDTH(FW), .CELL_INDEX_WIDTH(CW), .DATA_WORDS(DW), .MAGIC(MAGIC)) dut (
    .auroraClk(auroraClk), .auroraReset(auroraReset), .FAstrobe(FAstrobe),
    .allBPMpresent(allBPMpresent), .TVALID(TVALID), .TLAST(TLAST), .TDATA(TDATA),
    .statusStrobe(statusStrobe), .statusCode(statusCode), .statusFOFBenabled(statusFOFBenabled),
    .statusCellIndex(statusCellIndex), .bpmBitmap(bpmBitmap), .cellCounter(cellCounter),
    .frontBank(frontBank), .readoutAddress(readoutAddress), .readoutData(readoutData));

  always #5 auroraClk = ~auroraClk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [NREC-1:0] m_bm;
  int              m_cnt;
  int              m_front;
  logic            m_en;
  logic [CW-1:0]   m_cell;
  logic [RW-1:0]   m_mem   [2][NREC];
  bit              m_known [2][NREC];
  logic [31:0]     pb [DW];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame_checks();
    chk("bitmap", bpmBitmap, m_bm);
    chk("cellCounter", cellCounter, m_cnt);
    chk("frontBank", frontBank, m_front);
  endtask

  // Drives one packet (header + pb payload + filler up to len beats, TLAST on the last)
  // and checks every strobe and the frame state afterwards.
  task automatic send_packet(input logic [31:0] hdr, input int len, input bit allp);
    bit          es [16];
    logic [2:0]  ec [16];
    logic [RW-1:0] rec;
    logic [31:0] s, d;
    bit          bad, present, dup;
    logic [2:0]  code;
    int          idx;
    for (int i = 0; i < 16; i++) begin es[i] = 0; ec[i] = 3'd0; end
    idx = int'(hdr[FW-1:0]);
    if (len == 1) begin
      es[0] = 1; ec[0] = 3'd2;
    end else if (hdr[31:16] != MAGIC) begin
      es[0] = 1; ec[0] = 3'd1;
      es[len-1] = 1; ec[len-1] = 3'd1;
    end else begin
      m_en   = hdr[15];
      m_cell = hdr[10 +: CW];
      es[len-1] = 1;
      if (len <= DW + 1) begin
        ec[len-1] = 3'd2;
      end else begin
        s       = pb[DW-1];
        bad     = s[30];
        present = !s[31];
        dup     = present && m_bm[idx] && !bad;
        code    = bad ? 3'd3 : (dup ? 3'd4 : 3'd0);
        ec[len-1] = code;
        if (present && !dup && !allp) begin
          for (int k = 0; k < DW; k++) rec[k*32 +: 32] = pb[k];
          m_mem[1-m_front][idx]   = rec;
          m_known[1-m_front][idx] = 1;
        end
        if (code == 3'd0) begin
          if (m_cnt < CMAX) m_cnt++;
          if (!allp) m_bm[idx] = 1'b1;
        end
      end
    end
    allBPMpresent = allp;
    for (int b = 0; b < len; b++) begin
      if ($urandom_range(0, 5) == 0) begin
        TVALID = 1'b0; TLAST = $urandom_range(0, 1); TDATA = $urandom;
        @(negedge auroraClk);
        chk("idle_strobe", statusStrobe, 1'b0);
      end
      if (b == 0)       d = hdr;
      else if (b <= DW) d = pb[b-1];
      else              d = $urandom;
      TVALID = 1'b1; TDATA = d; TLAST = (b == len - 1);
      @(negedge auroraClk);
      chk("strobe", statusStrobe, es[b]);
      if (es[b]) begin
        chk("code", statusCode, ec[b]);
        chk("cell", statusCellIndex, m_cell);
        chk("enable", statusFOFBenabled, m_en);
      end
    end
    TVALID = 1'b0; TLAST = 1'b0;
    frame_checks();
  endtask

  task automatic fa(input bit with_beat, input logic [31:0] d);
    FAstrobe = 1'b1; TVALID = with_beat; TDATA = d; TLAST = 1'b0;
    @(negedge auroraClk);
    FAstrobe = 1'b0; TVALID = 1'b0;
    m_front = 1 - m_front; m_bm = '0; m_cnt = 0;
    frame_checks();
    chk("fa_code", statusCode, 3'd0);
    chk("fa_strobe", statusStrobe, 1'b0);
  endtask

  task automatic read_chk(input int a);
    readoutAddress = FW'(a);
    @(negedge auroraClk);
    chk("readout", readoutData, m_mem[m_front][a]);
  endtask

  task automatic read_known();
    for (int a = 0; a < 16; a++) if (m_known[m_front][a]) read_chk(a);
  endtask

  function automatic logic [31:0] rand_hdr(input bit good, input int idx);
    logic [31:0] h;
    logic [15:0] hi;
    h = $urandom;
    h[FW-1:0] = FW'(idx);
    hi = h[31:16];
    if (good) hi = MAGIC;
    else if (hi == MAGIC) hi = hi ^ 16'h0001;
    h[31:16] = hi;
    return h;
  endfunction

  initial begin
    logic [31:0] h, s;
    int len, r;
    bit good;
    for (int b = 0; b < 2; b++) for (int a = 0; a < NREC; a++) m_known[b][a] = 0;
    m_bm = '0; m_cnt = 0; m_front = 0; m_en = 0; m_cell = '0;
    auroraReset = 1'b1; FAstrobe = 0; allBPMpresent = 0; TVALID = 0; TLAST = 0;
    TDATA = '0; readoutAddress = '0;
    repeat (3) @(negedge auroraClk);
    chk("rst_strobe", statusStrobe, 1'b0);
    chk("rst_code", statusCode, 3'd0);
    chk("rst_enable", statusFOFBenabled, 1'b0);
    chk("rst_cell", statusCellIndex, 0);
    frame_checks();
    auroraReset = 1'b0;
    @(negedge auroraClk);

    // good packet, then swap and read back
    pb[0] = 32'h11; pb[1] = 32'h22; pb[2] = 32'h0;
    send_packet(32'hA5BE8C05, DW + 2, 0);
    chk("tp_code", statusCode, 3'd0);
    chk("tp_cell", statusCellIndex, 3);
    chk("tp_en", statusFOFBenabled, 1'b1);
    chk("tp_bm5", bpmBitmap[5], 1'b1);
    chk("tp_cnt", cellCounter, 1);
    fa(0, 32'h0);
    read_chk(5);
    chk("tp_rd5", readoutData, {32'h0, 32'h22, 32'h11});

    // bad header then a normal packet
    pb[0] = 32'h33; pb[1] = 32'h44; pb[2] = 32'h0;
    send_packet(32'h12340005, DW + 2, 0);
    send_packet(32'hA5BE0007, DW + 2, 0);
    // short packet: TLAST on the Y beat
    send_packet(32'hA5BE0009, 3, 0);
    chk("short_code", statusCode, 3'd2);
    send_packet(32'hA5BE000A, DW + 2, 0);

    // duplicate index in one frame
    pb[0] = 32'h11; pb[1] = 32'h22; pb[2] = 32'h0;
    send_packet(32'hA5BE0405, DW + 2, 0);
    pb[0] = 32'h99;
    send_packet(32'hA5BE0405, DW + 2, 0);
    chk("dup_code", statusCode, 3'd4);
    fa(0, 32'h0);
    read_chk(5);
    chk("dup_rd5", readoutData[31:0], 32'h11);

    // bad packet and not-present status words
    pb[2] = 32'h40000000;
    send_packet(32'hA5BE000B, DW + 2, 0);
    pb[2] = 32'h80000000;
    send_packet(32'hA5BE000C, DW + 2, 0);

    // FAstrobe coincident with a header beat
    fa(1, 32'hA5BE000D);
    pb[2] = 32'h0;
    send_packet(32'hA5BE000E, DW + 2, 0);

    // reset mid-DATA
    TVALID = 1'b1; TLAST = 1'b0; TDATA = 32'hA5BE000F;
    @(negedge auroraClk);
    TDATA = 32'h55;
    @(negedge auroraClk);
    TVALID = 1'b0;
    auroraReset = 1'b1;
    #2;
    m_bm = '0; m_cnt = 0; m_front = 0; m_en = 0; m_cell = '0;
    chk("mid_rst_strobe", statusStrobe, 1'b0);
    chk("mid_rst_code", statusCode, 3'd0);
    chk("mid_rst_cell", statusCellIndex, 0);
    frame_checks();
    @(negedge auroraClk);
    auroraReset = 1'b0;
    send_packet(32'hA5BE0010, DW + 2, 0);
    read_known();

    // cellCounter saturation
    fa(0, 32'h0);
    pb[2] = 32'h80000000;
    for (int i = 0; i < CMAX + 3; i++) send_packet(rand_hdr(1, i % 16), DW + 2, 0);
    chk("sat_cnt", cellCounter, CMAX);

    // randomized traffic
    for (int p = 0; p < 300; p++) begin
      good = ($urandom_range(0, 6) != 0);
      h = rand_hdr(good, $urandom_range(0, 15));
      for (int k = 0; k < DW; k++) pb[k] = $urandom;
      s = $urandom & 32'h3FFF_FFFF;
      r = $urandom_range(0, 9);
      if (r < 2) s[31] = 1'b1;
      if (r == 2 || r == 3) s[30] = 1'b1;
      pb[DW-1] = s;
      r = $urandom_range(0, 9);
      if (r < 6)       len = DW + 2;
      else if (r == 6) len = DW + 2 + $urandom_range(1, 2);
      else             len = $urandom_range(good ? 1 : 2, DW + 1);
      send_packet(h, len, $urandom_range(0, 7) == 0);
      if (p % 25 == 24) begin
        fa($urandom_range(0, 1), $urandom);
        read_known();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fofb_frame_gather.md
# fofb_frame_gather

Parametrised successor to the single-bank FOFB link reader. Parses BPM packets from one Aurora cell-link stream, each packet a header plus DATA_WORDS payload words, and stores each valid record by FOFB index. Storage is double-banked: the back bank fills during an FA frame, and FAstrobe swaps banks so readout always sees one complete, consistent frame. Runs entirely in the Aurora clock domain and adds duplicate-index detection per frame.

## Interface
- FOFB_INDEX_WIDTH, 9, record address width; 2^FOFB_INDEX_WIDTH records per bank
- CELL_INDEX_WIDTH, 5, cell index width in header
- DATA_WORDS, 3, payload words per packet (2..8); last payload word is the status word
- MAGIC, 16'hA5BE, required header bits [31:16]

Ports:
- auroraClk  in  1  sole clock
- auroraReset  in  1  asynchronous, active-high reset
- FAstrobe  in  1  one-cycle frame marker
- allBPMpresent  in  1  when high, suppress record writes and bitmap updates
- TVALID  in  1  stream beat valid
- TLAST  in  1  final beat of packet
- TDATA  in  32  stream data
- statusStrobe  out  1  one-cycle pulse per terminated packet
- statusCode  out  3  0 SUCCESS, 1 BAD_HEADER, 2 BAD_SIZE, 3 BAD_PACKET, 4 DUPLICATE
- statusFOFBenabled  out  1  header bit 15 of last good header
- statusCellIndex  out  CELL_INDEX_WIDTH  header cell index of last good header
- bpmBitmap  out  2^FOFB_INDEX_WIDTH  indices recorded this frame
- cellCounter  out  CELL_INDEX_WIDTH+1  SUCCESS packets this frame (saturating)
- frontBank  out  1  bank currently presented to readout
- readoutAddress  in  FOFB_INDEX_WIDTH  front-bank record select
- readoutData  out  32*DATA_WORDS  record, word 0 in bits [31:0]

## Operation
- Header fields: magic [31:16], enable [15], cell [10+:CELL_INDEX_WIDTH], index [0+:FOFB_INDEX_WIDTH].
- States: HEADER -> DATA (word counter 0..DATA_WORDS-1) -> LAST -> HEADER. Transitions only on TVALID beats.
- HEADER: if magic matches, latch index, cell and enable; set statusCode SUCCESS; go to DATA. If magic does not match: statusCode BAD_HEADER, strobe, go to LAST (discard to TLAST).
- DATA: shift each word into the record register. On the status word (counter DATA_WORDS-1):
  - bit30=1 sets BAD_PACKET.
  - bit31=0 marks the record present.
  - If present, bpmBitmap[index] already set, and BAD_PACKET is not set: DUPLICATE, no write.
  - Otherwise, if present and !allBPMpresent: write the record to the back bank at index.
  - Then go to LAST.
- LAST: on TLAST, strobe with the current code. If SUCCESS: increment cellCounter, and if !allBPMpresent set bpmBitmap[index]. Go to HEADER. Non-TLAST beats are ignored.
- TLAST seen in HEADER or DATA: BAD_SIZE, strobe, go to HEADER, no write.
- FAstrobe takes priority over any coincident beat, which is dropped:
  - toggle frontBank; clear bpmBitmap and cellCounter; statusCode SUCCESS; go to HEADER.
  - A packet in progress is abandoned without a strobe.
- cellCounter saturates at all-ones.

## Timing
- Reset values: state HEADER; frontBank 0; all status outputs, bpmBitmap, cellCounter and statusStrobe are 0. readoutData is undefined until the first read. Memory is not reset.
- statusStrobe and the status fields become valid on the cycle after the terminating beat. The status fields hold until the next strobe.
- A record write commits on the cycle after the status-word beat.
- bpmBitmap and cellCounter update on the cycle after the TLAST beat.
- readoutData is registered: address at cycle N gives data at N+1 from the front bank as of cycle N.
- FAstrobe at cycle N: frontBank flips at N+1. A read issued at N+1 returns the new front bank at N+2.
- Back-to-back packets with no idle cycles are supported. HEADER accepts the beat immediately after TLAST.
- Asserting auroraReset mid-packet returns the block to its reset state immediately. Bank contents are retained.

## Test plan
- Good packet, DATA_WORDS=3: header 0xA5BE8C05, X 0x11, Y 0x22, S 0x0, then TLAST beat -> strobe with code 0, cell 3, enable 1; bpmBitmap[5]=1; cellCounter=1. After FAstrobe, reading address 5 returns {0x0,0x22,0x11}.
- Header 0x12340005 -> code 1 one cycle later; no write; the following packet parses normally.
- TLAST on the Y beat -> code 2; bpmBitmap unchanged; next header accepted on the next beat.
- Second packet with index 5 in the same frame and new data 0x99 -> code 4; after swap, address 5 still reads X 0x11.
- Status word 0x40000000 -> code 3 and no bitmap bit. Status word 0x80000000 -> code 0, cellCounter increments, no write.
- FAstrobe coincident with a header beat -> beat dropped and frontBank toggles. Reset asserted mid-DATA -> all outputs 0, then parsing resumes with the next header.
